// File: rtl/cpu_trace_formatter.sv
// Converts register/memory write trace records into ASCII frames streamed one character per
// valid/ready handshake. Defining TRACE_NEWLINE_EN appends 8'h0A after the closing "#".
module cpu_trace_formatter (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_kind,
    input  logic [15:0] i_time,
    input  logic [31:0] i_pc,
    input  logic [4:0]  i_grf,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic [7:0]  o_char,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_frame_done,
    output logic [1:0]  o_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, EMIT = 2'd2} state_t;

    // Frame segments in emission order; a segment's width may depend on the record.
    localparam logic [3:0] SEG_CARET = 4'd0;
    localparam logic [3:0] SEG_TIME  = 4'd1;
    localparam logic [3:0] SEG_AT    = 4'd2;
    localparam logic [3:0] SEG_PC    = 4'd3;
    localparam logic [3:0] SEG_SEP   = 4'd4;
    localparam logic [3:0] SEG_FIELD = 4'd5;
    localparam logic [3:0] SEG_ARROW = 4'd6;
    localparam logic [3:0] SEG_DATA  = 4'd7;
    localparam logic [3:0] SEG_HASH  = 4'd8;
`ifdef TRACE_NEWLINE_EN
    localparam logic [3:0] SEG_LAST  = 4'd9;
`else
    localparam logic [3:0] SEG_LAST  = SEG_HASH;
`endif

    state_t      r_state;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_frame_done;
    logic [7:0]  r_char;
    logic        r_kind;
    logic [31:0] r_pc;
    logic [4:0]  r_grf;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [3:0]  r_seg;
    logic [2:0]  r_idx;

    logic [13:0] w_time_sat;
    logic [15:0] w_bcd_adj;
    logic [2:0]  w_nt;
    logic [2:0]  w_nr;
    logic [1:0]  w_grf_tens;
    logic [3:0]  w_grf_ones;
    logic [2:0]  w_seg_last;
    logic [3:0]  w_next_seg;
    logic [2:0]  w_next_idx;
    logic [1:0]  w_tsel;
    logic [2:0]  w_hsel;
    logic [7:0]  w_next_char;
    logic        w_frame_last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] n);
        return 8'h30 + {4'h0, n};
    endfunction

    assign w_time_sat = (i_time > 16'd9999) ? 14'd9999 : i_time[13:0];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? (r_bcd[4*k +: 4] + 4'd3)
                                                             : r_bcd[4*k +: 4];
        end
    end

    always_comb begin
        w_nt = 3'd1;
        if (r_bcd[15:12] != 4'd0)     w_nt = 3'd4;
        else if (r_bcd[11:8] != 4'd0) w_nt = 3'd3;
        else if (r_bcd[7:4] != 4'd0)  w_nt = 3'd2;

        w_grf_tens = 2'd0;
        w_grf_ones = 4'(r_grf);
        if (r_grf >= 5'd30) begin
            w_grf_tens = 2'd3;
            w_grf_ones = 4'(r_grf - 5'd30);
        end else if (r_grf >= 5'd20) begin
            w_grf_tens = 2'd2;
            w_grf_ones = 4'(r_grf - 5'd20);
        end else if (r_grf >= 5'd10) begin
            w_grf_tens = 2'd1;
            w_grf_ones = 4'(r_grf - 5'd10);
        end
        w_nr = (r_grf >= 5'd10) ? 3'd2 : 3'd1;

        case (r_seg)
            SEG_TIME:          w_seg_last = w_nt - 3'd1;
            SEG_PC, SEG_DATA:  w_seg_last = 3'd7;
            SEG_SEP:           w_seg_last = 3'd2;
            SEG_FIELD:         w_seg_last = r_kind ? 3'd7 : (w_nr - 3'd1);
            SEG_ARROW:         w_seg_last = 3'd3;
            default:           w_seg_last = 3'd0;
        endcase

        if (r_idx == w_seg_last) begin
            w_next_seg = r_seg + 4'd1;
            w_next_idx = 3'd0;
        end else begin
            w_next_seg = r_seg;
            w_next_idx = r_idx + 3'd1;
        end
        w_frame_last = (r_seg == SEG_LAST);

        // Time digits go most significant first; hex fields go nibble 7 down to 0.
        w_tsel = 2'(w_nt - 3'd1 - w_next_idx);
        w_hsel = 3'd7 - w_next_idx;

        case (w_next_seg)
            SEG_CARET: w_next_char = "^";
            SEG_TIME:  w_next_char = dec_char(r_bcd[{w_tsel, 2'b00} +: 4]);
            SEG_AT:    w_next_char = "@";
            SEG_PC:    w_next_char = hex_char(r_pc[{w_hsel, 2'b00} +: 4]);
            SEG_SEP:   w_next_char = (w_next_idx == 3'd0) ? ":" :
                                     (w_next_idx == 3'd1) ? " " : (r_kind ? "*" : "$");
            SEG_FIELD: begin
                if (r_kind)
                    w_next_char = hex_char(r_addr[{w_hsel, 2'b00} +: 4]);
                else if ((w_nr == 3'd2) && (w_next_idx == 3'd0))
                    w_next_char = dec_char({2'b00, w_grf_tens});
                else
                    w_next_char = dec_char(w_grf_ones);
            end
            SEG_ARROW: w_next_char = (w_next_idx == 3'd0) ? " " :
                                     (w_next_idx == 3'd1) ? "<" :
                                     (w_next_idx == 3'd2) ? "=" : " ";
            SEG_DATA:  w_next_char = hex_char(r_data[{w_hsel, 2'b00} +: 4]);
            SEG_HASH:  w_next_char = "#";
            default:   w_next_char = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_char       <= 8'h00;
            r_kind       <= 1'b0;
            r_pc         <= 32'h0;
            r_grf        <= 5'h0;
            r_addr       <= 32'h0;
            r_data       <= 32'h0;
            r_bin        <= 14'h0;
            r_bcd        <= 16'h0;
            r_cnt        <= 4'h0;
            r_seg        <= SEG_CARET;
            r_idx        <= 3'h0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_kind     <= i_kind;
                        r_pc       <= i_pc;
                        r_grf      <= i_grf;
                        r_addr     <= i_addr;
                        r_data     <= i_data;
                        r_bin      <= w_time_sat;
                        r_bcd      <= 16'h0;
                        r_cnt      <= 4'h0;
                        r_in_ready <= 1'b0;
                        r_state    <= CONV;
                    end
                end
                CONV: begin
                    // Fourteen shift-add-3 steps, then one edge to present "^".
                    if (r_cnt == 4'd14) begin
                        r_state     <= EMIT;
                        r_seg       <= SEG_CARET;
                        r_idx       <= 3'd0;
                        r_char      <= "^";
                        r_out_valid <= 1'b1;
                    end else begin
                        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
                        r_cnt          <= r_cnt + 4'd1;
                    end
                end
                EMIT: begin
                    if (i_out_ready) begin
                        if (w_frame_last) begin
                            r_out_valid  <= 1'b0;
                            r_frame_done <= 1'b1;
                            r_in_ready   <= 1'b1;
                            r_state      <= IDLE;
                        end else begin
                            r_seg  <= w_next_seg;
                            r_idx  <= w_next_idx;
                            r_char <= w_next_char;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_out_valid  = r_out_valid;
    assign o_frame_done = r_frame_done;
    assign o_char       = r_char;
    assign o_state      = r_state;

endmodule

// File: tb/tb_cpu_trace_formatter.sv
// Bench for cpu_trace_formatter: literal frame table, hand sequences for stalls/reset,
// and random records checked against a string-formatting reference model.
module tb_cpu_trace_formatter;

`ifdef TRACE_NEWLINE_EN
    localparam int NL = 1;
`else
    localparam int NL = 0;
`endif
    localparam int NV = 7;

    logic        clk;
    logic        reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic        i_kind;
    logic [15:0] i_time;
    logic [31:0] i_pc;
    logic [4:0]  i_grf;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic [7:0]  o_char;
    logic        o_out_valid;
    logic        i_out_ready;
    logic        o_frame_done;
    logic [1:0]  o_state;

    cpu_trace_formatter dut (
        .clk          (clk),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_kind       (i_kind),
        .i_time       (i_time),
        .i_pc         (i_pc),
        .i_grf        (i_grf),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .o_char       (o_char),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_frame_done (o_frame_done),
        .o_state      (o_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int acc_cyc;
    int first_cyc;
    bit fd_seen, fd_bad, fd_ready, busy_ready, bubble, stall_bad;

    typedef struct {
        logic        kind;
        logic [15:0] t;
        logic [31:0] pc;
        logic [4:0]  grf;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;
    } vec_t;

    vec_t  vecs[NV];
    string vexp[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    task automatic chk_text(input string name);
        int bad = -1;
        for (int i = 0; i < exp_q.size(); i++)
            if (bad < 0 && (i >= got_q.size() || got_q[i] !== exp_q[i])) bad = i;
        if (bad < 0 && got_q.size() != exp_q.size()) bad = exp_q.size();
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s text: differs at char %0d, got \"%s\" expected \"%s\"",
                     name, bad, q2s(got_q), q2s(exp_q));
        end
    endtask

    function automatic int ndig(input int v);
        int n = 1;
        while (v >= 10) begin
            v = v / 10;
            n++;
        end
        return n;
    endfunction

    // Reference model: the frame is just a formatted string of the record.
    task automatic model_frame(input logic k, input logic [15:0] t, input logic [31:0] pc,
                               input logic [4:0] grf, input logic [31:0] addr,
                               input logic [31:0] data, output int len);
        int ts;
        string s;
        ts = (int'(t) > 9999) ? 9999 : int'(t);
        if (k == 1'b0) s = $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, grf, data);
        else           s = $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, addr, data);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
        if (NL == 1) exp_q.push_back(8'h0A);
        len = (k == 1'b0) ? (26 + ndig(ts) + ndig(int'(grf))) : (34 + ndig(ts));
        len = len + NL;
    endtask

    task automatic load_exp(input string s);
        exp_q.delete();
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
        if (NL == 1) exp_q.push_back(8'h0A);
    endtask

    // Driver: called at a negedge; presents the record until the acceptance edge.
    task automatic send_record(input logic k, input logic [15:0] t, input logic [31:0] pc,
                               input logic [4:0] grf, input logic [31:0] addr,
                               input logic [31:0] data);
        int n = 0;
        while (!o_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", o_in_ready, 1);
        i_in_valid = 1'b1;
        i_kind = k; i_time = t; i_pc = pc; i_grf = grf; i_addr = addr; i_data = data;
        acc_cyc = cyc + 1;
        @(negedge clk);
        i_in_valid = 1'b0;
        i_kind = 1'($urandom); i_time = 16'($urandom); i_pc = $urandom;
        i_grf = 5'($urandom); i_addr = $urandom; i_data = $urandom;
    endtask

    // mode 0: sink always ready; mode 1: sink ready pseudo-randomly.
    task automatic collect_frame(input int mode);
        bit started = 0, prev_take = 0, prev_stall = 0, done = 0, rdy;
        logic [7:0] prev_char = 8'h00;
        got_q.delete();
        first_cyc = -1;
        fd_seen = 0; fd_bad = 0; fd_ready = 0; busy_ready = 0; bubble = 0; stall_bad = 0;
        for (int n = 0; n < 3000 && !done; n++) begin
            if (o_frame_done) begin
                fd_seen = 1;
                fd_bad = !prev_take || o_out_valid;
                fd_ready = o_in_ready;
                done = 1;
                i_out_ready = 1'b0;
            end else begin
                if (o_in_ready) busy_ready = 1;
                if (o_out_valid) begin
                    if (!started) begin
                        started = 1;
                        first_cyc = cyc;
                    end
                    if (prev_stall && o_char !== prev_char) stall_bad = 1;
                end else if (started) begin
                    bubble = 1;
                end
                rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
                i_out_ready = rdy;
                prev_take = o_out_valid && rdy;
                prev_stall = o_out_valid && !rdy;
                prev_char = o_char;
                if (prev_take) got_q.push_back(o_char);
                @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input string name, input int mode, input logic k,
                             input logic [15:0] t, input logic [31:0] pc, input logic [4:0] grf,
                             input logic [31:0] addr, input logic [31:0] data,
                             input int exp_len);
        send_record(k, t, pc, grf, addr, data);
        collect_frame(mode);
        chk({name, "_frame_done_seen"}, fd_seen, 1);
        chk({name, "_len"}, got_q.size(), exp_len);
        chk_text(name);
        chk({name, "_first_latency"}, first_cyc - acc_cyc, 15);
        chk({name, "_done_timing"}, fd_bad, 0);
        chk({name, "_ready_when_done"}, fd_ready, 1);
        chk({name, "_ready_while_busy"}, busy_ready, 0);
        chk({name, "_bubble"}, bubble, 0);
        chk({name, "_stall_hold"}, stall_bad, 0);
    endtask

    initial begin
        int taken, len;
        bit hit, quiet_bad;
        logic k;
        logic [15:0] t;
        logic [4:0] g;
        logic [31:0] pc, ad, da;

        vecs[0] = '{1'b0, 16'd42,    32'h00003004, 5'd28, 32'h5555aaaa, 32'hff00ff00, 30};
        vexp[0] = "^42@00003004: $28 <= ff00ff00#";
        vecs[1] = '{1'b1, 16'd0,     32'h00000000, 5'd17, 32'h0000000c, 32'h00000001, 35};
        vexp[1] = "^0@00000000: *0000000c <= 00000001#";
        vecs[2] = '{1'b0, 16'd12345, 32'h80000000, 5'd0,  32'h12345678, 32'hdeadbeef, 31};
        vexp[2] = "^9999@80000000: $0 <= deadbeef#";
        vecs[3] = '{1'b1, 16'd9999,  32'h00401a2c, 5'd31, 32'hfffffffc, 32'h1234abcd, 38};
        vexp[3] = "^9999@00401a2c: *fffffffc <= 1234abcd#";
        vecs[4] = '{1'b0, 16'd10000, 32'h00000010, 5'd31, 32'hffffffff, 32'h00000000, 32};
        vexp[4] = "^9999@00000010: $31 <= 00000000#";
        vecs[5] = '{1'b0, 16'd9,     32'habcdef01, 5'd9,  32'h0, 32'h0000000a, 28};
        vexp[5] = "^9@abcdef01: $9 <= 0000000a#";
        vecs[6] = '{1'b1, 16'd100,   32'h12345678, 5'd3,  32'h00000000, 32'h87654321, 37};
        vexp[6] = "^100@12345678: *00000000 <= 87654321#";

        // Reset, with in_valid held high to show reset wins
        reset = 1'b1; i_in_valid = 1'b1; i_out_ready = 1'b1;
        i_kind = 1'b0; i_time = 16'd5; i_pc = 32'h0; i_grf = 5'd1; i_addr = 32'h0; i_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", o_in_ready, 1);
        chk("reset_out_valid", o_out_valid, 0);
        chk("reset_char", o_char, 8'h00);
        chk("reset_frame_done", o_frame_done, 0);
        chk("reset_state", o_state, 2'd0);
        i_in_valid = 1'b0; i_out_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < NV; v++) begin
            load_exp(vexp[v]);
            run_frame($sformatf("vec%0d", v), 0, vecs[v].kind, vecs[v].t, vecs[v].pc,
                      vecs[v].grf, vecs[v].addr, vecs[v].data, vecs[v].len + NL);
        end

        // Sink stalls pseudo-randomly on the first table record
        load_exp(vexp[0]);
        run_frame("stall", 1, vecs[0].kind, vecs[0].t, vecs[0].pc, vecs[0].grf,
                  vecs[0].addr, vecs[0].data, vecs[0].len + NL);

        // Reset while the 10th character is presented
        send_record(vecs[0].kind, vecs[0].t, vecs[0].pc, vecs[0].grf, vecs[0].addr, vecs[0].data);
        taken = 0;
        hit = 0;
        for (int n = 0; n < 100 && !hit; n++) begin
            if (o_out_valid) begin
                if (taken == 9) hit = 1;
                else begin
                    i_out_ready = 1'b1;
                    taken++;
                end
            end
            if (!hit) @(negedge clk);
        end
        chk("abort_reached_10th", hit, 1);
        chk("abort_10th_char", o_char, 8'h30);
        reset = 1'b1; i_out_ready = 1'b1; i_in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0; i_in_valid = 1'b0;
        chk("abort_out_valid", o_out_valid, 0);
        chk("abort_char", o_char, 8'h00);
        chk("abort_in_ready", o_in_ready, 1);
        chk("abort_state", o_state, 2'd0);
        quiet_bad = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (o_out_valid || o_frame_done) quiet_bad = 1;
        end
        chk("abort_no_resume", quiet_bad, 0);
        i_out_ready = 1'b0;
        load_exp(vexp[1]);
        run_frame("after_abort", 0, vecs[1].kind, vecs[1].t, vecs[1].pc, vecs[1].grf,
                  vecs[1].addr, vecs[1].data, vecs[1].len + NL);

        // Random records against the model
        for (int r = 0; r < 24; r++) begin
            k = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       t = 16'($urandom_range(0, 9));
                1:       t = 16'($urandom_range(0, 999));
                2:       t = 16'($urandom_range(0, 9999));
                default: t = 16'($urandom_range(9990, 65535));
            endcase
            g = 5'($urandom_range(0, 31));
            pc = $urandom; ad = $urandom; da = $urandom;
            model_frame(k, t, pc, g, ad, da, len);
            run_frame($sformatf("rand%0d", r), r % 2, k, t, pc, g, ad, da, len);
        end

        @(negedge clk);
        chk("frame_done_one_cycle", o_frame_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_trace_formatter.md
CPU_TRACE_FORMATTER -- requirements
Module: cpu_trace_formatter

Interface
REQ-001 SHALL have clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have in_valid, input, 1 bit: a trace record is presented.
REQ-004 SHALL have in_ready, output, 1 bit: the formatter accepts a record when this is high in the same cycle as in_valid.
REQ-005 SHALL have kind, input, 1 bit: 0 = register write, 1 = memory write.
REQ-006 SHALL have time, input, 16 bits: cycle stamp, unsigned.
REQ-007 SHALL have pc, input, 32 bits: instruction address.
REQ-008 SHALL have grf, input, 5 bits: destination register number (kind=0).
REQ-009 SHALL have addr, input, 32 bits: memory address (kind=1).
REQ-010 SHALL have data, input, 32 bits: written value.
REQ-011 SHALL have char, output, 8 bits: ASCII character.
REQ-012 SHALL have out_valid, output, 1 bit: char is valid.
REQ-013 SHALL have out_ready, input, 1 bit: the sink takes char when out_valid and out_ready are both high.
REQ-014 SHALL have frame_done, output, 1 bit: one-cycle pulse after the last character of a frame is taken.

Function
REQ-015 SHALL emit kind=0 frames as "^" T "@" P ": $" R " <= " D "#".
REQ-016 SHALL emit kind=1 frames as "^" T "@" P ": *" A " <= " D "#".
REQ-017 SHALL format fields as:
- T: time in decimal, 1-4 digits, no leading zeros; time=0 emits "0".
- P, A, D: exactly 8 lowercase hex digits (0-9, a-f), zero-padded.
- R: grf in decimal, 1-2 digits, no leading zeros.
REQ-018 SHALL saturate time values above 9999 to 9999.
REQ-019 SHALL register all record fields on the acceptance edge, so input changes afterwards have no effect on the frame in progress.
REQ-020 SHALL implement three states: IDLE, CONV and EMIT.
REQ-021 SHALL drive in_ready high only in IDLE.
REQ-022 SHALL move from IDLE to CONV on acceptance.
REQ-023 SHALL, in CONV, run a 14-cycle iterative shift-add-3 binary-to-BCD conversion of the saturated time, then move to EMIT.
REQ-024 SHALL assert out_valid with char "^" on the 15th rising edge after the acceptance edge.
REQ-025 SHALL hold out_valid high throughout EMIT, and SHALL hold char stable while out_valid is high and out_ready is low.
REQ-026 SHALL advance exactly one character per cycle in which out_valid and out_ready are both high, with no bubbles between characters.
REQ-027 SHALL, when the final character is taken, deassert out_valid on the next edge, pulse frame_done for one cycle and return to IDLE.
REQ-028 SHALL accept a new record no earlier than the cycle in which frame_done is high.
REQ-029 SHALL produce a frame of length 26+T+R for kind=0 and 34+T for kind=1, where T and R are the digit counts.
REQ-030 SHALL emit byte-exact frames that the team's cpu_checker classifies as format_type 01 (kind=0) or 10 (kind=1).

Reset
REQ-031 SHALL, on reset, force state=IDLE, in_ready=1, out_valid=0, char=8'h00, frame_done=0 and clear all counters and the BCD register.
REQ-032 SHALL, on reset mid-CONV or mid-EMIT, abort the frame with no resumption; out_valid is 0 from the next cycle and no frame_done is generated.
REQ-033 SHALL give reset priority over in_valid and out_ready in the same cycle.

Configuration
REQ-034 SHALL, when TRACE_NEWLINE_EN is defined, append 8'h0A after "#", adding 1 to each frame length; frame_done then follows the newline.
REQ-035 SHALL, without TRACE_NEWLINE_EN, end every frame at "#".

Verification
REQ-036 SHALL cover: kind=0, time=42, pc=0x00003004, grf=28, data=0xff00ff00, out_ready=1 -> "^42@00003004: $28 <= ff00ff00#" (30 chars), first char 15 cycles after acceptance, frame_done one cycle after "#".
REQ-037 SHALL cover: kind=1, time=0, pc=0x00000000, addr=0x0000000c, data=0x1 -> "^0@00000000: *0000000c <= 00000001#" (35 chars).
REQ-038 SHALL cover: time=12345, grf=0 -> T field "9999", R field "0".
REQ-039 SHALL cover: out_ready toggling pseudo-randomly -> character sequence identical to REQ-036, with char unchanged during every stall cycle.
REQ-040 SHALL cover: reset asserted on the 10th emitted character -> out_valid=0 next cycle, no frame_done, next record emitted complete from "^".
REQ-041 SHALL cover: build with TRACE_NEWLINE_EN on the REQ-036 record -> 31 chars ending "#", 8'h0A; the stream fed to cpu_checker yields format_type=01 after "#".
